// File: rtl/in_service_ctrl_n.sv
// In-service register with rotating priority, EOI handling, nest depth and protocol-error flag.
// Optional IN_SERVICE_AUTO_EOI_EN adds an auto_eoi input that acknowledges without setting the ISR.

module in_service_ctrl_n_lane (
  input  logic isr_bit,
  input  logic clr_bit,
  input  logic set_bit,
  input  logic eoi_bit,
  output logic nxt_bit,
  output logic eoi_err
);
  // Set wins over a clear of the same level in the same cycle.
  assign nxt_bit = (isr_bit & ~clr_bit) | set_bit;
  assign eoi_err = eoi_bit & ~isr_bit;
endmodule

module in_service_ctrl_n #(
  parameter  int NUM_LEVELS = 8,
  localparam int LEVEL_W    = $clog2(NUM_LEVELS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_priority,
  input  logic [LEVEL_W-1:0]    priority_rotate_in,
  input  logic                  rotate_on_eoi,
  input  logic [NUM_LEVELS-1:0] interrupt,
  input  logic                  start_in_service,
  input  logic [NUM_LEVELS-1:0] end_of_interrupt,
  input  logic                  non_specific_eoi,
`ifdef IN_SERVICE_AUTO_EOI_EN
  input  logic                  auto_eoi,
`endif
  output logic [NUM_LEVELS-1:0] in_service_register,
  output logic [NUM_LEVELS-1:0] highest_level_in_service,
  output logic [LEVEL_W-1:0]    priority_rotate,
  output logic [LEVEL_W:0]      nest_depth,
  output logic                  protocol_error
);

  logic                  auto_en;
  logic [NUM_LEVELS-1:0] isr_nxt, clr, set, eoi_err;
  logic [LEVEL_W-1:0]    hi_idx, lvl, ack_idx, ptr_nxt;
  logic                  hi_found, ack_onehot, ack_ok, dup_err, err_nxt;
  logic [LEVEL_W:0]      depth_nxt;

`ifdef IN_SERVICE_AUTO_EOI_EN
  assign auto_en = auto_eoi;
`else
  assign auto_en = 1'b0;
`endif

  // Scan from lowest to highest priority so the last hit is the highest-priority level.
  always_comb begin
    hi_idx   = '0;
    hi_found = 1'b0;
    lvl      = '0;
    for (int i = NUM_LEVELS-1; i >= 0; i--) begin
      lvl = priority_rotate + LEVEL_W'(i + 1);
      if (in_service_register[lvl]) begin
        hi_idx   = lvl;
        hi_found = 1'b1;
      end
    end
  end

  assign highest_level_in_service = NUM_LEVELS'(hi_found) << hi_idx;

  always_comb begin
    ack_idx = '0;
    for (int i = 0; i < NUM_LEVELS; i++)
      if (interrupt[i]) ack_idx = LEVEL_W'(i);
  end

  assign ack_onehot = (interrupt != '0) && ((interrupt & (interrupt - 1'b1)) == '0);
  assign ack_ok     = start_in_service & ack_onehot;
  assign clr        = end_of_interrupt | (non_specific_eoi ? highest_level_in_service : '0);
  assign set        = (ack_ok & ~auto_en) ? interrupt : '0;

  genvar g;
  generate
    for (g = 0; g < NUM_LEVELS; g++) begin : g_lane
      in_service_ctrl_n_lane u_lane (
        .isr_bit (in_service_register[g]),
        .clr_bit (clr[g]),
        .set_bit (set[g]),
        .eoi_bit (end_of_interrupt[g]),
        .nxt_bit (isr_nxt[g]),
        .eoi_err (eoi_err[g])
      );
    end
  endgenerate

  always_comb begin
    depth_nxt = '0;
    for (int i = 0; i < NUM_LEVELS; i++)
      depth_nxt = depth_nxt + (LEVEL_W+1)'(isr_nxt[i]);
  end

  // A repeated acknowledge is only an error if the level is not also being cleared now.
  assign dup_err = ack_ok && ((in_service_register & interrupt) != '0) && ((clr & interrupt) == '0);

  assign err_nxt = (start_in_service & ~ack_onehot)
                 | dup_err
                 | (non_specific_eoi & ~hi_found)
                 | (|eoi_err);

  always_comb begin
    ptr_nxt = priority_rotate;
    if (non_specific_eoi && rotate_on_eoi && hi_found)
      ptr_nxt = hi_idx;
    else if (auto_en && ack_ok && rotate_on_eoi)
      ptr_nxt = ack_idx;
    else if (set_priority)
      ptr_nxt = priority_rotate_in;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      in_service_register <= '0;
      priority_rotate     <= LEVEL_W'(NUM_LEVELS-1);
      nest_depth          <= '0;
      protocol_error      <= 1'b0;
    end else begin
      in_service_register <= isr_nxt;
      priority_rotate     <= ptr_nxt;
      nest_depth          <= depth_nxt;
      protocol_error      <= err_nxt;
    end
  end

endmodule

// File: tb/tb_in_service_ctrl_n.sv
// Randomized and directed bench for in_service_ctrl_n against a behavioural model.
module tb_in_service_ctrl_n;
  localparam int N = 8;

  logic       clock = 1'b0;
  logic       reset_n, set_priority, rotate_on_eoi, start_in_service, non_specific_eoi, auto_eoi;
  logic [2:0] priority_rotate_in;
  logic [N-1:0] interrupt, end_of_interrupt;
  logic [N-1:0] in_service_register, highest_level_in_service;
  logic [2:0] priority_rotate;
  logic [3:0] nest_depth;
  logic       protocol_error;

  int checks = 0;
  int failures = 0;

  logic [N-1:0] m_isr;
  int           m_ptr;
  logic         m_err;
  bit           m_valid = 1'b0;

  always #5 clock = ~clock;

  in_service_ctrl_n #(.NUM_LEVELS(N)) dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .set_priority             (set_priority),
    .priority_rotate_in       (priority_rotate_in),
    .rotate_on_eoi            (rotate_on_eoi),
    .interrupt                (interrupt),
    .start_in_service         (start_in_service),
    .end_of_interrupt         (end_of_interrupt),
    .non_specific_eoi         (non_specific_eoi),
`ifdef IN_SERVICE_AUTO_EOI_EN
    .auto_eoi                 (auto_eoi),
`endif
    .in_service_register      (in_service_register),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .nest_depth               (nest_depth),
    .protocol_error           (protocol_error)
  );

  // Walk priorities from highest ((ptr+1) mod N) downward; -1 when nothing is in service.
  function automatic int hi_of(logic [N-1:0] isr, int ptr);
    for (int k = 1; k <= N; k++)
      if (isr[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  task automatic model_step();
    int hi, idx;
    logic [N-1:0] clr, set;
    bit oh;
    if (!reset_n) begin
      m_isr = '0; m_ptr = N-1; m_err = 1'b0; m_valid = 1'b1;
      return;
    end
    hi  = hi_of(m_isr, m_ptr);
    clr = end_of_interrupt;
    if (non_specific_eoi && hi >= 0) clr[hi] = 1'b1;
    oh  = ($countones(interrupt) == 1);
    idx = 0;
    for (int i = 0; i < N; i++) if (interrupt[i]) idx = i;
    set = (start_in_service && oh && !auto_eoi) ? interrupt : '0;
    m_err = (start_in_service && !oh)
         || (start_in_service && oh && m_isr[idx] && !clr[idx])
         || (non_specific_eoi && m_isr == 0)
         || ((end_of_interrupt & ~m_isr) != 0);
    m_isr = (m_isr & ~clr) | set;
    if (non_specific_eoi && rotate_on_eoi && hi >= 0) m_ptr = hi;
    else if (auto_eoi && start_in_service && oh && rotate_on_eoi) m_ptr = idx;
    else if (set_priority) m_ptr = priority_rotate_in;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int hi;
    if (!m_valid) return;
    hi = hi_of(m_isr, m_ptr);
    chk("isr", 32'(in_service_register), 32'(m_isr));
    chk("highest", 32'(highest_level_in_service), (hi < 0) ? 32'd0 : (32'd1 << hi));
    chk("ptr", 32'(priority_rotate), 32'(m_ptr));
    chk("depth", 32'(nest_depth), 32'($countones(m_isr)));
    chk("perr", 32'(protocol_error), 32'(m_err));
  endtask

  task automatic idle();
    reset_n = 1'b1; set_priority = 1'b0; priority_rotate_in = '0; rotate_on_eoi = 1'b0;
    interrupt = '0; start_in_service = 1'b0; end_of_interrupt = '0; non_specific_eoi = 1'b0;
    auto_eoi = 1'b0;
  endtask

  // Inputs are stable from negedge; the model consumes them, then outputs are checked at the next negedge.
  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare_all();
    rotate_on_eoi = rotate_on_eoi;
    reset_n = 1'b1; set_priority = 1'b0; interrupt = '0; start_in_service = 1'b0;
    end_of_interrupt = '0; non_specific_eoi = 1'b0;
  endtask

  task automatic ack(logic [N-1:0] v);
    interrupt = v; start_in_service = 1'b1; tick();
  endtask

  task automatic eoi(logic [N-1:0] v);
    end_of_interrupt = v; tick();
  endtask

  task automatic nseoi();
    non_specific_eoi = 1'b1; tick();
  endtask

  initial begin
    idle();
    @(negedge clock);
    reset_n = 1'b0; tick();
    reset_n = 1'b0; tick();
    chk("rst_isr", 32'(in_service_register), 32'h0);
    chk("rst_ptr", 32'(priority_rotate), 32'd7);
    chk("rst_depth", 32'(nest_depth), 32'd0);
    chk("rst_perr", 32'(protocol_error), 32'd0);

    for (int i = 7; i >= 0; i--) ack(8'(1 << i));
    chk("fill_isr", 32'(in_service_register), 32'hFF);
    chk("fill_depth", 32'(nest_depth), 32'd8);
    chk("fill_hi", 32'(highest_level_in_service), 32'h01);
    for (int i = 0; i < 8; i++) begin
      eoi(8'(1 << i));
      chk("seoi_perr", 32'(protocol_error), 32'd0);
    end
    chk("drain_isr", 32'(in_service_register), 32'h00);
    chk("drain_depth", 32'(nest_depth), 32'd0);

    set_priority = 1'b1; priority_rotate_in = 3'd3; tick();
    chk("setp_ptr", 32'(priority_rotate), 32'd3);
    ack(8'h20); ack(8'h01);
    chk("rot_hi", 32'(highest_level_in_service), 32'h20);
    nseoi();
    chk("ns_isr", 32'(in_service_register), 32'h01);
    eoi(8'h01);

    set_priority = 1'b1; priority_rotate_in = 3'd7; tick();
    ack(8'h04); ack(8'h08);
    rotate_on_eoi = 1'b1; nseoi(); rotate_on_eoi = 1'b0;
    chk("roe_isr", 32'(in_service_register), 32'h08);
    chk("roe_ptr", 32'(priority_rotate), 32'd2);
    chk("roe_hi", 32'(highest_level_in_service), 32'h08);
    eoi(8'h08);

    ack(8'h04);
    interrupt = 8'h04; start_in_service = 1'b1; end_of_interrupt = 8'h04; tick();
    chk("same_isr", 32'(in_service_register), 32'h04);
    chk("same_perr", 32'(protocol_error), 32'd0);

    ack(8'h06);
    chk("bad_oh_perr", 32'(protocol_error), 32'd1);
    chk("bad_oh_isr", 32'(in_service_register), 32'h04);
    tick();
    chk("pulse_end", 32'(protocol_error), 32'd0);
    ack(8'h04);
    chk("dup_perr", 32'(protocol_error), 32'd1);
    chk("dup_isr", 32'(in_service_register), 32'h04);
    tick();
    chk("pulse_end2", 32'(protocol_error), 32'd0);
    eoi(8'h04);
    nseoi();
    chk("empty_ns_perr", 32'(protocol_error), 32'd1);
    chk("empty_ns_ptr", 32'(priority_rotate), 32'd2);
    tick();
    chk("pulse_end3", 32'(protocol_error), 32'd0);

    for (int i = 0; i < 8; i++) ack(8'(1 << i));
    reset_n = 1'b0; interrupt = 8'h01; start_in_service = 1'b1; tick();
    chk("midrst_isr", 32'(in_service_register), 32'h00);
    chk("midrst_ptr", 32'(priority_rotate), 32'd7);
    chk("midrst_depth", 32'(nest_depth), 32'd0);

`ifdef IN_SERVICE_AUTO_EOI_EN
    auto_eoi = 1'b1; rotate_on_eoi = 1'b1; ack(8'h10);
    auto_eoi = 1'b0; rotate_on_eoi = 1'b0;
    chk("auto_isr", 32'(in_service_register), 32'h00);
    chk("auto_ptr", 32'(priority_rotate), 32'd4);
`endif

    for (int c = 0; c < 3000; c++) begin
      reset_n            = ($urandom_range(99, 0) != 0);
      start_in_service   = ($urandom_range(2, 0) == 0);
      interrupt          = ($urandom_range(5, 0) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(7, 0));
      end_of_interrupt   = ($urandom_range(3, 0) != 0) ? 8'h00 :
                           (($urandom_range(3, 0) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(7, 0)));
      non_specific_eoi   = ($urandom_range(4, 0) == 0);
      set_priority       = ($urandom_range(7, 0) == 0);
      priority_rotate_in = 3'($urandom);
      rotate_on_eoi      = $urandom_range(1, 0) == 1;
`ifdef IN_SERVICE_AUTO_EOI_EN
      auto_eoi           = ($urandom_range(3, 0) == 0);
`endif
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
